// File: rtl/axi_wr_burst_arbiter.sv
// Round-robin scheduler of per-channel write bursts onto one AXI write engine, with ping-pong frame addressing.
// Optional feature macro: ARB_FIXED_PRIORITY_EN (lowest channel index always wins, no rotation pointer).
module axi_wr_burst_arbiter #(
  parameter int                    CH_NUM           = 2,
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    BURST_BYTES      = 2048,
  parameter int                    BURSTS_PER_FRAME = 540,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] CH_STRIDE        = ADDR_WIDTH'(32'h0080_0000),
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE     = ADDR_WIDTH'(32'h0040_0000)
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic [CH_NUM-1:0]     ch_burst_valid,
  output logic [CH_NUM-1:0]     ch_burst_ready,
  input  logic [CH_NUM-1:0]     ch_frame_start,
  output logic                  wr_start,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0]            wr_ch,
  input  logic                  wr_done,
  output logic                  busy,
  output logic [CH_NUM-1:0]     rd_buf_sel
);

  localparam int LINE_W = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(BURSTS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t                  state_r, next_state_s;
  logic                    grant_valid_s, grant_take_s, done_adv_s;
  logic [1:0]              grant_ch_s;
  logic [CH_NUM-1:0]       ready_nxt_s;
  logic [LINE_W-1:0]       sel_line_s;
  logic                    sel_buf_s;
  logic [LINE_W-1:0]       line_cnt_r [CH_NUM];
  logic [CH_NUM-1:0]       wr_buf_r;
  logic [CH_NUM-1:0]       rd_buf_sel_r;
  logic [CH_NUM-1:0]       ready_r;
  logic                    wr_start_r, busy_r;
  logic [1:0]              wr_ch_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;

  function automatic logic [ADDR_WIDTH-1:0] calc_addr(input logic [1:0] ch, input logic bsel,
                                                      input logic [LINE_W-1:0] line);
    calc_addr = BASE_ADDR + ADDR_WIDTH'(ch) * CH_STRIDE + ADDR_WIDTH'(bsel) * FRAME_STRIDE
              + ADDR_WIDTH'(line) * ADDR_WIDTH'(BURST_BYTES);
  endfunction

`ifdef ARB_FIXED_PRIORITY_EN
  // Winner selection: lowest requesting index (loop runs downward so the lowest assignment lands last).
  always_comb begin
    grant_valid_s = |ch_burst_valid;
    grant_ch_s    = 2'd0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      grant_ch_s = ch_burst_valid[k] ? 2'(k) : grant_ch_s;
    end
  end
`else
  logic [1:0] rr_ptr_r;

  // Winner selection: requesting channel with the smallest rotational distance from rr_ptr.
  always_comb begin
    int   best_v;
    int   dist_v;
    logic take_v;
    best_v        = CH_NUM;
    dist_v        = 0;
    take_v        = 1'b0;
    grant_valid_s = |ch_burst_valid;
    grant_ch_s    = 2'd0;
    for (int k = 0; k < CH_NUM; k++) begin
      dist_v     = (k + CH_NUM - int'(rr_ptr_r)) % CH_NUM;
      take_v     = ch_burst_valid[k] && (dist_v < best_v);
      best_v     = take_v ? dist_v : best_v;
      grant_ch_s = take_v ? 2'(k) : grant_ch_s;
    end
  end

  // Rotation pointer moves past the channel just issued.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rr_ptr_r <= 2'd0;
    end else if (state_r == ISSUE) begin
      rr_ptr_r <= (wr_ch_r == 2'(CH_NUM - 1)) ? 2'd0 : wr_ch_r + 2'd1;
    end
  end
`endif

  // Per-channel views of the winner: one-hot acknowledge plus its current line/buffer.
  always_comb begin
    ready_nxt_s = '0;
    sel_line_s  = '0;
    sel_buf_s   = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      ready_nxt_s[k] = (grant_ch_s == 2'(k));
      sel_line_s     = (grant_ch_s == 2'(k)) ? line_cnt_r[k] : sel_line_s;
      sel_buf_s      = (grant_ch_s == 2'(k)) ? wr_buf_r[k] : sel_buf_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = grant_valid_s ? ISSUE : IDLE;
      ISSUE:   next_state_s = WAIT;
      WAIT:    next_state_s = wr_done ? IDLE : WAIT;
      default: next_state_s = IDLE;
    endcase
  end

  assign grant_take_s = (state_r == IDLE) && grant_valid_s;
  assign done_adv_s   = (state_r == WAIT) && wr_done;

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant-time outputs are loaded on the IDLE->ISSUE edge so they are all valid during ISSUE.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_start_r <= 1'b0;
      ready_r    <= '0;
      busy_r     <= 1'b0;
      wr_ch_r    <= 2'd0;
      wr_addr_r  <= '0;
    end else begin
      wr_start_r <= grant_take_s;
      ready_r    <= grant_take_s ? ready_nxt_s : '0;
      busy_r     <= (next_state_s != IDLE);
      if (grant_take_s) begin
        wr_ch_r   <= grant_ch_s;
        wr_addr_r <= calc_addr(grant_ch_s, sel_buf_s, sel_line_s);
      end
    end
  end

  // Line counters and ping-pong buffers; a frame_start on the same channel overrides the completion advance.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      for (int k = 0; k < CH_NUM; k++) begin
        line_cnt_r[k] <= '0;
      end
      wr_buf_r     <= '0;
      rd_buf_sel_r <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (ch_frame_start[k]) begin
          line_cnt_r[k] <= '0;
        end else if (done_adv_s && (wr_ch_r == 2'(k))) begin
          if (line_cnt_r[k] == LAST_LINE) begin
            line_cnt_r[k]   <= '0;
            rd_buf_sel_r[k] <= wr_buf_r[k];
            wr_buf_r[k]     <= ~wr_buf_r[k];
          end else begin
            line_cnt_r[k] <= line_cnt_r[k] + LINE_W'(1);
          end
        end
      end
    end
  end

  assign wr_start       = wr_start_r;
  assign ch_burst_ready = ready_r;
  assign busy           = busy_r;
  assign wr_ch          = wr_ch_r;
  assign wr_addr        = wr_addr_r;
  assign rd_buf_sel     = rd_buf_sel_r;

endmodule

// File: tb/tb_axi_wr_burst_arbiter.sv
// Randomised self-checking bench for axi_wr_burst_arbiter against a transaction-level model
// (arbitration order, per-channel line/buffer bookkeeping, address arithmetic).
module tb_axi_wr_burst_arbiter;

  localparam int CH_NUM = 2;
  localparam int BPF    = 540;
  localparam longint BASE = 64'h0000_0000, CHS = 64'h0080_0000, FRS = 64'h0040_0000, BB = 2048;

  logic              clk, rst_n;
  logic [CH_NUM-1:0] ch_burst_valid, ch_burst_ready, ch_frame_start, rd_buf_sel;
  logic              wr_start, wr_done, busy;
  logic [31:0]       wr_addr;
  logic [1:0]        wr_ch;

  int n_tests = 0;
  int n_fail  = 0;

  int line_m  [CH_NUM];
  int bsel_m  [CH_NUM];
  int rdsel_m [CH_NUM];
  int rr_m;

  axi_wr_burst_arbiter #(
    .CH_NUM(CH_NUM), .ADDR_WIDTH(32), .BURST_BYTES(2048), .BURSTS_PER_FRAME(BPF),
    .BASE_ADDR(32'h0000_0000), .CH_STRIDE(32'h0080_0000), .FRAME_STRIDE(32'h0040_0000)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .ch_burst_valid(ch_burst_valid), .ch_burst_ready(ch_burst_ready),
    .ch_frame_start(ch_frame_start), .wr_start(wr_start), .wr_addr(wr_addr),
    .wr_ch(wr_ch), .wr_done(wr_done), .busy(busy), .rd_buf_sel(rd_buf_sel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH_NUM; k++) begin
      line_m[k] = 0; bsel_m[k] = 0; rdsel_m[k] = 0;
    end
    rr_m = 0;
  endtask

  function automatic int model_winner(input logic [CH_NUM-1:0] m);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < CH_NUM; i++) if (m[i]) return i;
`else
    for (int i = 0; i < CH_NUM; i++) if (m[(rr_m + i) % CH_NUM]) return (rr_m + i) % CH_NUM;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] model_addr(input int w);
    logic [63:0] a;
    a = BASE + longint'(w) * CHS + longint'(bsel_m[w]) * FRS + longint'(line_m[w]) * BB;
    return a[31:0];
  endfunction

  function automatic logic [CH_NUM-1:0] model_rdsel();
    logic [CH_NUM-1:0] v;
    for (int k = 0; k < CH_NUM; k++) v[k] = rdsel_m[k][0];
    return v;
  endfunction

  task automatic model_done(input int w, input bit fs_en, input int fs_ch);
    if (!(fs_en && fs_ch == w)) begin
      if (line_m[w] == BPF - 1) begin
        line_m[w] = 0; rdsel_m[w] = bsel_m[w]; bsel_m[w] = 1 - bsel_m[w];
      end else begin
        line_m[w] = line_m[w] + 1;
      end
    end
    if (fs_en) line_m[fs_ch] = 0;
  endtask

  task automatic check_zero(input string p);
    check_val({p, "_start"}, wr_start, 0);
    check_val({p, "_ready"}, ch_burst_ready, 0);
    check_val({p, "_addr"}, wr_addr, 0);
    check_val({p, "_ch"}, wr_ch, 0);
    check_val({p, "_busy"}, busy, 0);
    check_val({p, "_rdsel"}, rd_buf_sel, 0);
  endtask

  // One full grant: request, check ISSUE outputs, d idle WAIT cycles, then wr_done (+ optional frame_start).
  task automatic do_round(input logic [CH_NUM-1:0] mask, input int d_in, input bit fs_en,
                          input int fs_ch, input bit glitch, output logic [31:0] obs_addr);
    int w, d, n;
    logic [31:0] ea;
    d  = (glitch && d_in == 0) ? 1 : d_in;
    w  = model_winner(mask);
    ea = model_addr(w);
    ch_burst_valid = mask;
    @(posedge clk); #1;
    n = 0;
    while (!wr_start && n < 8) begin
      @(posedge clk); #1; n++;
    end
    obs_addr = wr_addr;
    check_val("start", wr_start, 1);
    check_val("wr_ch", wr_ch, w);
    check_val("ready", ch_burst_ready, 64'(1) << w);
    check_val("addr", wr_addr, ea);
    check_val("busy_issue", busy, 1);
    ch_burst_valid = '0;
    rr_m = (w + 1) % CH_NUM;
    @(posedge clk); #1;
    check_val("start_pulse", wr_start, 0);
    check_val("ready_pulse", ch_burst_ready, 0);
    for (int i = 0; i < d; i++) begin
      if (glitch && i == 0) ch_burst_valid = '1;
      @(posedge clk); #1;
      ch_burst_valid = '0;
    end
    check_val("addr_hold", wr_addr, ea);
    check_val("busy_wait", busy, 1);
    wr_done = 1'b1;
    if (fs_en) ch_frame_start[fs_ch] = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0;
    ch_frame_start = '0;
    model_done(w, fs_en, fs_ch);
    check_val("busy_idle", busy, 0);
    check_val("rd_buf_sel", rd_buf_sel, model_rdsel());
  endtask

  task automatic pulse_fs(input int ch);
    ch_frame_start[ch] = 1'b1;
    @(posedge clk); #1;
    ch_frame_start = '0;
    line_m[ch] = 0;
    check_val("fs_busy", busy, 0);
  endtask

  task automatic idle_check(input int n, input bit spurious);
    if (spurious) wr_done = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_done = 1'b0;
      check_val("idle_start", wr_start, 0);
      check_val("idle_busy", busy, 0);
    end
  endtask

  task automatic reset_in_wait();
    ch_burst_valid = 1;
    @(posedge clk); #1;
    ch_burst_valid = '0;
    @(posedge clk); #1;
    check_val("rst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    clk = 1'b0; rst_n = 1'b0; ch_burst_valid = '0; ch_frame_start = '0; wr_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_reset");

    // single requester
    do_round(2'b01, 4, 0, 0, 0, a);
    check_val("tp_single0", a, 32'h0000_0000);
    do_round(2'b01, 4, 0, 0, 0, a);
    check_val("tp_single1", a, 32'h0000_0800);

    // contention
    do_round(2'b11, 1, 0, 0, 0, a);
`ifndef ARB_FIXED_PRIORITY_EN
    check_val("tp_ch1_first", a, 32'h0080_0000);
`endif
    for (int i = 0; i < 5; i++) do_round(2'b11, i % 3, 0, 0, 0, a);

    // spurious done while idle, request glitch during WAIT
    idle_check(3, 1);
    do_round(2'b01, 2, 0, 0, 1, a);
    idle_check(3, 0);

    // frame restart on ch1
    for (int i = 0; i < 10; i++) do_round(2'b10, 0, 0, 0, 0, a);
    pulse_fs(1);
    do_round(2'b10, 1, 0, 0, 0, a);
    check_val("tp_fs_restart", a, 32'h0080_0000);
    do_round(2'b10, 1, 1, 1, 0, a);
    do_round(2'b10, 1, 0, 0, 0, a);
    check_val("tp_fs_coincide", a, 32'h0080_0000);

    // reset mid-burst
    reset_in_wait();
    do_round(2'b01, 1, 0, 0, 0, a);
    check_val("tp_after_rst", a, 32'h0000_0000);

    // frame wrap on ch0
    pulse_fs(0);
    for (int i = 0; i <= 2 * BPF; i++) begin
      do_round(2'b01, 0, 0, 0, 0, a);
      if (i == BPF) check_val("tp_wrap_pong", a, 32'h0040_0000);
      if (i == 2 * BPF) check_val("tp_wrap_ping", a, 32'h0000_0000);
      if (i == BPF - 1) check_val("tp_rdsel_f1", rd_buf_sel[0], 0);
      if (i == 2 * BPF - 1) check_val("tp_rdsel_f2", rd_buf_sel[0], 1);
    end

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [CH_NUM-1:0] m;
      m = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
      do_round(m, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, CH_NUM - 1),
               ($urandom_range(0, 9) == 0), a);
      if ($urandom_range(0, 15) == 0) pulse_fs($urandom_range(0, CH_NUM - 1));
      if ($urandom_range(0, 15) == 0) idle_check(1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
